// File: rtl/speed_bcd_entry.sv
// Keypad BCD speed entry: two-digit rolling entry, clamped commit on ENTER.
// Optional idle-entry timeout when SPEED_ENTRY_TIMEOUT_EN is defined.
module speed_bcd_entry #(
  parameter int SPEED_MIN      = 1,
  parameter int SPEED_MAX      = 99,
  parameter int SPEED_INIT     = 5,
  parameter int TIMEOUT_CYCLES = 50000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic [7:0] speed,
  output logic       speed_valid,
  output logic [3:0] entry_one,
  output logic [3:0] entry_ten,
  output logic       entry_active
);

  typedef enum logic [1:0] {
    IDLE,
    D1,
    D2,
    COMMIT
  } state_t;

  localparam logic [3:0] BLANK   = 4'd10;
  localparam logic [3:0] K_ENTER = 4'd10;
  localparam logic [3:0] K_CLEAR = 4'd11;
  localparam logic [7:0] SMIN    = 8'(SPEED_MIN);
  localparam logic [7:0] SMAX    = 8'(SPEED_MAX);
  localparam logic [7:0] SINIT   = 8'(SPEED_INIT);

  if (SPEED_MAX > 99 || SPEED_MIN < 0 ||
      SPEED_MIN > SPEED_MAX ||
      SPEED_INIT < SPEED_MIN ||
      SPEED_INIT > SPEED_MAX ||
      TIMEOUT_CYCLES < 2) begin : g_bad_cfg
    $error("speed_bcd_entry: bad parameters");
  end

  state_t     state, state_nx;
  logic [3:0] one_nx, ten_nx;
  logic [7:0] speed_nx;
  logic       valid_nx;
  logic       active_nx;

  logic is_digit, is_enter, is_clear;
  logic expire;

  assign is_digit = key_valid && (key_code <= 4'd9);
  assign is_enter = key_valid && (key_code == K_ENTER);
  assign is_clear = key_valid && (key_code == K_CLEAR);

  // BCD to binary; ten*10 as shift-add, blank tens reads as zero
  logic [3:0] ten_bin;
  logic [6:0] ten7;
  logic [6:0] value;
  logic [7:0] value8;
  logic [7:0] clamped;

  assign ten_bin = (entry_ten == BLANK) ? 4'd0 : entry_ten;
  assign ten7    = {3'b000, ten_bin};
  assign value   = (ten7 << 3) + (ten7 << 1)
                 + {3'b000, entry_one};
  assign value8  = {1'b0, value};

  always_comb begin
    clamped = value8;
    if (value8 < SMIN) clamped = SMIN;
    if (value8 > SMAX) clamped = SMAX;
  end

`ifdef SPEED_ENTRY_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] TLAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt, cnt_nx;
  logic          in_entry;

  assign in_entry = (state == D1) || (state == D2);

  // any acted-on key in the expiry cycle takes priority
  assign expire = in_entry && (cnt == TLAST) &&
                  !(key_valid && (key_code <= K_CLEAR));

  always_comb begin
    cnt_nx = '0;
    if (in_entry && !is_digit) cnt_nx = cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_nx;
    end
  end
`else
  assign expire = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    one_nx   = entry_one;
    ten_nx   = entry_ten;
    speed_nx = speed;
    valid_nx = 1'b0;
    unique case (state)
      IDLE: begin
        one_nx = BLANK;
        ten_nx = BLANK;
        if (is_digit) begin
          one_nx   = key_code;
          state_nx = D1;
        end
      end
      D1, D2: begin
        unique case (1'b1)
          is_digit: begin
            ten_nx   = entry_one;
            one_nx   = key_code;
            state_nx = D2;
          end
          is_enter: state_nx = COMMIT;
          is_clear, expire: begin
            one_nx   = BLANK;
            ten_nx   = BLANK;
            state_nx = IDLE;
          end
          default: ;
        endcase
      end
      COMMIT: begin
        speed_nx = clamped;
        valid_nx = 1'b1;
        one_nx   = BLANK;
        ten_nx   = BLANK;
        state_nx = IDLE;
      end
      default: begin
        one_nx   = BLANK;
        ten_nx   = BLANK;
        state_nx = IDLE;
      end
    endcase
  end

  assign active_nx = (state_nx == D1) || (state_nx == D2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      entry_one    <= BLANK;
      entry_ten    <= BLANK;
      speed        <= SINIT;
      speed_valid  <= 1'b0;
      entry_active <= 1'b0;
    end else begin
      state        <= state_nx;
      entry_one    <= one_nx;
      entry_ten    <= ten_nx;
      speed        <= speed_nx;
      speed_valid  <= valid_nx;
      entry_active <= active_nx;
    end
  end

endmodule

// File: tb/tb_speed_bcd_entry.sv
// Scoreboard bench for speed_bcd_entry: directed keys, queued commit values.
// Timeout cases run only when SPEED_ENTRY_TIMEOUT_EN is defined.
module tb_speed_bcd_entry;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       key_valid;
  logic [3:0] key_code;
  logic [7:0] speed;
  logic       speed_valid;
  logic [3:0] entry_one;
  logic [3:0] entry_ten;
  logic       entry_active;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_q[$];
  logic [7:0] exp_v;

  localparam logic [3:0] ENT = 4'd10;
  localparam logic [3:0] CLR = 4'd11;

  speed_bcd_entry #(
    .SPEED_MIN(1),
    .SPEED_MAX(50),
    .SPEED_INIT(5),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .key_valid(key_valid),
    .key_code(key_code),
    .speed(speed),
    .speed_valid(speed_valid),
    .entry_one(entry_one),
    .entry_ten(entry_ten),
    .entry_active(entry_active)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, req);
    end
  endtask

  // called at a negedge; consecutive calls give back-to-back strobes
  task automatic press(input logic [3:0] c);
    key_valid = 1'b1;
    key_code  = c;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic commit(input logic [7:0] v);
    exp_q.push_back(v);
    press(ENT);
  endtask

  task automatic blank_chk(input string nm);
    check({nm, "_one"}, 32'(entry_one), 32'd10);
    check({nm, "_ten"}, 32'(entry_ten), 32'd10);
    check({nm, "_act"}, 32'(entry_active), 32'd0);
  endtask

  always @(negedge clk) begin
    if (rst_n && speed_valid) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL pulse: got speed_valid=1 speed=%0d want no pulse",
                 speed);
      end else begin
        exp_v = exp_q.pop_front();
        if (speed !== exp_v) begin
          bad++;
          $display("FAIL commit: got %0d want %0d", speed, exp_v);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    key_valid = 1'b0;
    key_code  = 4'd0;
    idle(2);
    rst_n = 1'b1;
    idle(1);
    check("rst_speed", 32'(speed), 32'd5);
    check("rst_valid", 32'(speed_valid), 32'd0);
    blank_chk("rst");

    press(4'd3);
    press(4'd8);
    check("mid_act", 32'(entry_active), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    blank_chk("async_rst");
    check("async_speed", 32'(speed), 32'd5);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    blank_chk("post_rst");

    press(4'd4);
    check("d1_one", 32'(entry_one), 32'd4);
    check("d1_ten", 32'(entry_ten), 32'd10);
    press(4'd2);
    check("d2_one", 32'(entry_one), 32'd2);
    check("d2_ten", 32'(entry_ten), 32'd4);
    check("d2_act", 32'(entry_active), 32'd1);
    commit(8'd42);
    check("commit_cyc_valid", 32'(speed_valid), 32'd0);
    idle(1);
    check("pulse_valid", 32'(speed_valid), 32'd1);
    idle(1);
    check("pulse_fall", 32'(speed_valid), 32'd0);
    check("hold_42", 32'(speed), 32'd42);
    blank_chk("after42");

    press(4'd1);
    press(4'd2);
    press(4'd3);
    check("roll_ten", 32'(entry_ten), 32'd2);
    check("roll_one", 32'(entry_one), 32'd3);
    commit(8'd23);
    idle(2);

    press(4'd7);
    commit(8'd7);
    idle(2);

    press(4'd0);
    commit(8'd1);
    idle(2);

    press(4'd9);
    press(4'd9);
    commit(8'd50);
    idle(2);
    check("clamp_hi", 32'(speed), 32'd50);

    press(4'd7);
    press(CLR);
    blank_chk("clear");
    press(ENT);
    idle(3);
    check("clear_speed", 32'(speed), 32'd50);

    press(ENT);
    press(4'd13);
    idle(2);
    blank_chk("idle_ign");

    press(4'd6);
    press(4'd13);
    press(4'd15);
    check("d1_ign_one", 32'(entry_one), 32'd6);
    check("d1_ign_act", 32'(entry_active), 32'd1);
    press(CLR);

    press(4'd2);
    press(4'd8);
    commit(8'd28);
    press(4'd9);
    idle(2);
    blank_chk("drop");
    check("drop_speed", 32'(speed), 32'd28);

`ifdef SPEED_ENTRY_TIMEOUT_EN
    press(4'd3);
    idle(15);
    check("to_still", 32'(entry_active), 32'd1);
    idle(1);
    blank_chk("to_expired");
    idle(3);
    check("to_speed", 32'(speed), 32'd28);

    press(4'd3);
    idle(15);
    press(4'd4);
    check("to_win_ten", 32'(entry_ten), 32'd3);
    check("to_win_one", 32'(entry_one), 32'd4);
    commit(8'd34);
    idle(2);
    check("to_win_spd", 32'(speed), 32'd34);
`endif

    idle(3);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/speed_bcd_entry.md
# speed_bcd_entry

Keypad-driven speed setter for the snake game. It accepts decimal digit keystrokes, shows the partial entry on the FND as ones/tens digit codes, and converts the entry from BCD to binary on ENTER. The result is clamped to a legal range and committed as the 8-bit game speed. It is the inverse of the speed-to-FND digit split: digits in, binary speed out. It sits between the key scanner and the game timing logic.

## Interface
- SPEED_MIN, 1, lowest committed speed (0 ≤ SPEED_MIN ≤ SPEED_MAX)
- SPEED_MAX, 99, highest committed speed (≤ 99)
- SPEED_INIT, 5, speed after reset (SPEED_MIN..SPEED_MAX)
- TIMEOUT_CYCLES, 50000000, idle-entry timeout; used only with SPEED_ENTRY_TIMEOUT_EN
- clk  in  1  system clock; the block uses one clock
- rst_n  in  1  asynchronous, active-low reset
- key_valid  in  1  one-cycle key strobe
- key_code  in  4  0–9 digit; 10 ENTER; 11 CLEAR; 12–15 ignored
- speed  out  8  committed binary speed
- speed_valid  out  1  one-cycle pulse on each commit
- entry_one  out  4  ones digit of the entry; 10 = blank
- entry_ten  out  4  tens digit of the entry; 10 = blank
- entry_active  out  1  high while in D1 or D2

## Operation
- FSM states: IDLE, D1, D2, COMMIT. Only keys with key_valid=1 are acted on. Codes 12–15 are ignored in every state.
- IDLE
  - entry_one = entry_ten = 10.
  - A digit sets entry_one to that digit and moves to D1.
  - ENTER and CLEAR are ignored.
- D1
  - A digit sets entry_ten to the old entry_one and entry_one to the new digit, then moves to D2.
  - ENTER moves to COMMIT. CLEAR moves to IDLE.
- D2
  - A digit shifts in the same way and stays in D2 (rolling: the last two digits are kept).
  - ENTER moves to COMMIT. CLEAR moves to IDLE.
- COMMIT (lasts exactly one cycle)
  - Computes value = ten*10 + one, with a blank tens digit treated as 0. ten*10 is formed as (ten<<3)+(ten<<1); the result is 7 bits wide, maximum 99.
  - Clamp: value < SPEED_MIN gives SPEED_MIN; value > SPEED_MAX gives SPEED_MAX.
  - Loads speed, pulses speed_valid, blanks both entry digits, and returns to IDLE.
  - key_valid during COMMIT is dropped.
- CLEAR blanks both entry digits; speed is unchanged and no pulse is issued.
- entry_active = (state == D1) or (state == D2).

## Timing
- Reset values: state IDLE, speed = SPEED_INIT, speed_valid = 0, entry_one = entry_ten = 10, entry_active = 0. Reset mid-entry discards the partial entry.
- All outputs are registered; there is no combinational path from key inputs to outputs.
- A digit sampled at edge k appears on entry_one/entry_ten after edge k.
- ENTER sampled at edge k: the block is in COMMIT during cycle k→k+1. speed and speed_valid update at edge k+1; speed_valid falls at edge k+2. The next key is accepted from edge k+2.
- Back-to-back key strobes on consecutive cycles are all processed, except a strobe landing in the COMMIT cycle.
- speed holds its value between commits.

## Configuration
- SPEED_ENTRY_TIMEOUT_EN defined:
  - A counter runs while in D1 or D2 and restarts on every accepted digit.
  - When the count reaches TIMEOUT_CYCLES-1 with no key, the entry is abandoned: the FSM goes to IDLE, the digits blank, and no speed_valid is issued.
  - If a key arrives in the expiry cycle, the key wins: it is processed and the counter restarts.
  - The counter is cleared on reset and in IDLE.
- SPEED_ENTRY_TIMEOUT_EN undefined: no counter is built, and a partial entry is held until ENTER, CLEAR or reset.

## Test plan
- Reset: assert rst_n=0 mid-entry, then release. Required: speed=5, speed_valid=0, entry_one=entry_ten=10, entry_active=0.
- Keys 4, 2, ENTER. Required: entry_ten=4 and entry_one=2 before ENTER; speed=42 with one speed_valid pulse at the edge after ENTER; digits blank afterwards.
- Keys 1, 2, 3, ENTER (rolling entry). Required: speed=23. A single key 7 followed by ENTER gives speed=7.
- Clamp, with SPEED_MIN=1 and SPEED_MAX=50. Keys 0, ENTER give speed=1. Keys 9, 9, ENTER give speed=50.
- Ignored keys:
  - 7, CLEAR, ENTER: speed unchanged, no pulse.
  - ENTER in IDLE, or code 13: no effect.
  - A strobe in the COMMIT cycle is dropped.
- Timeout, with the macro defined and TIMEOUT_CYCLES=16.
  - Key 3, then idle 16 cycles: IDLE, digits blank, no pulse.
  - Key 3, then key 4 at cycle 15, then ENTER: speed=34.
